// File: rtl/ir_rx_pkg.sv
// Shared types and constants for the IR packet receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ir_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    GAP   = 2'd2,
    BIT   = 2'd3
  } rx_state_e;

  localparam logic [7:0] STATUS_OFS  = 8'd0;
  localparam logic [7:0] CLEAR_OFS   = 8'd1;

  localparam int VALID_BIT   = 7;
  localparam int OVERRUN_BIT = 6;

  localparam int CNT_W = 12;

  // Assemble the status byte: {valid, overrun, 2'b00, data}
  function automatic logic [7:0] pack_status(input logic       valid,
                                             input logic       overrun,
                                             input logic [3:0] data);
    logic [7:0] s;
    s              = {4'b0000, data};
    s[VALID_BIT]   = valid;
    s[OVERRUN_BIT] = overrun;
    return s;
  endfunction

endpackage

// File: rtl/ir_envelope_detector.sv
// IR input synchroniser and (optional) carrier-to-envelope converter. Macro: IR_RX_CARRIER_EN.
// Latency: 2 cycles to the envelope; in carrier mode the envelope fall lags the last carrier rise by CARRIER_HOLD cycles.
// Backpressure: none; free-running on every clock.
module ir_envelope_detector #(
  parameter int CARRIER_HOLD = 3000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ir_i,
  output logic env_o
);

  logic sync1_q;
  logic sync2_q;

  // Two-flop synchroniser for the asynchronous IR pin
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= ir_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef IR_RX_CARRIER_EN
  localparam int HOLD_W = $clog2(CARRIER_HOLD + 1);

  logic              sync_prev_q;
  logic [HOLD_W-1:0] hold_q;

  // Retrigger the hold window on each carrier rising edge, then count down
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_prev_q <= 1'b0;
      hold_q      <= '0;
    end else begin
      sync_prev_q <= sync2_q;
      if (sync2_q && !sync_prev_q) begin
        hold_q <= HOLD_W'(CARRIER_HOLD);
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end
    end
  end

  assign env_o = (hold_q != '0);
`else
  assign env_o = sync2_q;
`endif

endmodule

// File: rtl/ir_receiver.sv
// Bus-mapped IR packet receiver: start burst + 4 data bursts -> 4-bit command, status register and IRQ. Macro: IR_RX_CARRIER_EN.
// Latency: commit one edge after the last burst fall is seen; bus read data driven the cycle after the address is sampled.
// Backpressure: none; a packet completing while status is still valid sets overrun and replaces the data.
module ir_receiver
  import ir_rx_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'hA0,
  parameter int         TICK_DIV     = 100,
  parameter int         START_MIN    = 1500,
  parameter int         BIT_THRESH   = 700,
  parameter int         GAP_TIMEOUT  = 2000,
  parameter int         CARRIER_HOLD = 3000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IR_IN,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       IRQ_RAISE,
  input  logic       IRQ_ACK
);

  localparam int                    PRE_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]      PRE_MAX      = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]      START_MIN_C  = CNT_W'(START_MIN);
  localparam logic [CNT_W-1:0]      BIT_THRESH_C = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0]      GAP_TO_C     = CNT_W'(GAP_TIMEOUT);
  localparam logic [7:0]            STATUS_ADDR  = BASE_ADDR + STATUS_OFS;
  localparam logic [7:0]            CLEAR_ADDR   = BASE_ADDR + CLEAR_OFS;

  logic             env;
  logic             env_prev_q;
  logic             env_rise;
  logic             env_fall;
  logic [PRE_W-1:0] pre_q;
  logic             tick;
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       bitcnt_q;
  logic [3:0]       shift_q;
  logic [3:0]       shift_d;
  logic             commit_q;
  logic [3:0]       data_q;
  logic             valid_q;
  logic             overrun_q;
  logic             irq_q;
  logic             rd_en_q;
  logic [7:0]       rd_dat_q;
  logic [7:0]       status;
  logic             clr_wr;
  logic             rd_req;

  ir_envelope_detector #(
    .CARRIER_HOLD (CARRIER_HOLD)
  ) u_env (
    .clk_i (CLK),
    .rst_i (RESET),
    .ir_i  (IR_IN),
    .env_o (env)
  );

  assign env_rise = env && !env_prev_q;
  assign env_fall = !env && env_prev_q;

  // Free-running tick prescaler; phase is deliberately not aligned to bursts
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
    end
  end

  assign tick    = (pre_q == PRE_MAX);
  assign cnt_d   = (tick && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  assign shift_d = {shift_q[2:0], (cnt_q >= BIT_THRESH_C)};

  // Packet FSM with duration counter; counter clears on every state change
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      commit_q   <= 1'b0;
      env_prev_q <= 1'b0;
    end else begin
      env_prev_q <= env;
      commit_q   <= 1'b0;
      cnt_q      <= cnt_d;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (env_rise) state_q <= START;
        end
        START: begin
          if (env_fall) begin
            cnt_q    <= '0;
            bitcnt_q <= '0;
            state_q  <= (cnt_q >= START_MIN_C) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (env_rise) begin
            cnt_q   <= '0;
            state_q <= BIT;
          end else if (cnt_q >= GAP_TO_C) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        BIT: begin
          if (env_fall) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            if (bitcnt_q == 2'd3) begin
              commit_q <= 1'b1;
              state_q  <= IDLE;
            end else begin
              bitcnt_q <= bitcnt_q + 1'b1;
              state_q  <= GAP;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clr_wr = BUS_WE && (BUS_ADDR == CLEAR_ADDR);
  assign rd_req = !BUS_WE && (BUS_ADDR == STATUS_ADDR);
  assign status = pack_status(valid_q, overrun_q, data_q);

  // Status and IRQ; a commit wins over a same-edge clear or acknowledge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (commit_q) begin
        data_q    <= shift_q;
        valid_q   <= 1'b1;
        overrun_q <= clr_wr ? 1'b0 : (overrun_q | valid_q);
      end else if (clr_wr) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (commit_q) begin
        irq_q <= 1'b1;
      end else if (IRQ_ACK) begin
        irq_q <= 1'b0;
      end
    end
  end

  // Registered read enable and data so the bus is driven for exactly the following cycle
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_en_q  <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      rd_en_q  <= rd_req;
      rd_dat_q <= status;
    end
  end

  assign BUS_DATA  = rd_en_q ? rd_dat_q : 8'bzzzz_zzzz;
  assign IRQ_RAISE = irq_q;

endmodule
